// File: rtl/gcd_operand_feeder.sv
// rtl/gcd_operand_feeder.sv - sequences reset, X/Y operand entry and Halt capture for the GCD processor.
// Optional WAIT_HALT watchdog enabled by defining GCD_FEED_TIMEOUT_EN.
module gcd_operand_feeder #(
  parameter int DATA_W       = 8,
  parameter int RST_CYCLES   = 2,
  parameter int SETUP_CYCLES = 3,
  parameter int ENTER_HOLD   = 3,
  parameter int GAP_CYCLES   = 3
`ifdef GCD_FEED_TIMEOUT_EN
  ,
  parameter int TIMEOUT      = 1023
`endif
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] x_in,
  input  logic [DATA_W-1:0] y_in,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              timeout_err,
  output logic              proc_reset,
  output logic [DATA_W-1:0] proc_dataIn,
  output logic              proc_enter,
  input  logic              proc_halt,
  input  logic [DATA_W-1:0] proc_dataOut
);

  localparam int MAX_A = (RST_CYCLES > SETUP_CYCLES) ? RST_CYCLES : SETUP_CYCLES;
  localparam int MAX_B = (ENTER_HOLD > GAP_CYCLES) ? ENTER_HOLD : GAP_CYCLES;
  localparam int MAX_P = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW    = $clog2(MAX_P + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_PRST, S_SETUP_X, S_ENTER_X, S_GAP_X,
    S_SETUP_Y, S_ENTER_Y, S_GAP_Y, S_WAIT_HALT, S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0] x_q, x_d, y_q, y_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic              busy_q, busy_d, done_q, done_d;
  logic              prst_q, prst_d, enter_q, enter_d;
  logic              terr_q, terr_d;

  // Counter preload on state entry: the state then lasts exactly N cycles.
  function automatic logic [CW-1:0] load_for(input state_t s);
    case (s)
      S_PRST:               load_for = CW'(RST_CYCLES - 1);
      S_SETUP_X, S_SETUP_Y: load_for = CW'(SETUP_CYCLES - 1);
      S_ENTER_X, S_ENTER_Y: load_for = CW'(ENTER_HOLD - 1);
      S_GAP_X, S_GAP_Y:     load_for = CW'(GAP_CYCLES - 1);
      default:              load_for = '0;
    endcase
  endfunction

`ifdef GCD_FEED_TIMEOUT_EN
  localparam int WDW = $clog2(TIMEOUT + 1);
  logic [WDW-1:0] wd_q, wd_d;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    x_d      = x_q;
    y_d      = y_q;
    result_d = result_q;
    case (state_q)
      S_IDLE: if (start) begin
        x_d     = x_in;
        y_d     = y_in;
        state_d = S_PRST;
      end
      S_PRST:    if (cnt_q == '0) state_d = S_SETUP_X;
      S_SETUP_X: if (cnt_q == '0) state_d = S_ENTER_X;
      S_ENTER_X: if (cnt_q == '0) state_d = S_GAP_X;
      S_GAP_X:   if (cnt_q == '0) state_d = S_SETUP_Y;
      S_SETUP_Y: if (cnt_q == '0) state_d = S_ENTER_Y;
      S_ENTER_Y: if (cnt_q == '0) state_d = S_GAP_Y;
      S_GAP_Y:   if (cnt_q == '0) state_d = S_WAIT_HALT;
      S_WAIT_HALT: begin
`ifdef GCD_FEED_TIMEOUT_EN
        // The watchdog has already pulsed in this final cycle, so it wins over a late Halt.
        if (wd_q == WDW'(TIMEOUT - 1)) begin
          state_d = S_IDLE;
        end else
`endif
        if (proc_halt) begin
          result_d = proc_dataOut;
          state_d  = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (state_d != state_q) cnt_d = load_for(state_d);
    else if (cnt_q != '0)   cnt_d = cnt_q - CW'(1);

    // Outputs are registered from the next state so they line up with state_q.
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_DONE);
    prst_d  = (state_d inside {S_IDLE, S_PRST});
    enter_d = (state_d inside {S_ENTER_X, S_ENTER_Y});
    if (state_d inside {S_SETUP_X, S_ENTER_X, S_GAP_X})
      din_d = x_d;
    else if (state_d inside {S_SETUP_Y, S_ENTER_Y, S_GAP_Y, S_WAIT_HALT})
      din_d = y_d;
    else
      din_d = '0;

`ifdef GCD_FEED_TIMEOUT_EN
    wd_d   = (state_d == S_WAIT_HALT && state_q == S_WAIT_HALT) ? wd_q + WDW'(1) : '0;
    terr_d = (state_d == S_WAIT_HALT) && (wd_d == WDW'(TIMEOUT - 1));
`else
    terr_d = 1'b0;
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      x_q      <= '0;
      y_q      <= '0;
      result_q <= '0;
      din_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      prst_q   <= 1'b1;
      enter_q  <= 1'b0;
      terr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      x_q      <= x_d;
      y_q      <= y_d;
      result_q <= result_d;
      din_q    <= din_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      prst_q   <= prst_d;
      enter_q  <= enter_d;
      terr_q   <= terr_d;
    end
  end

`ifdef GCD_FEED_TIMEOUT_EN
  always_ff @(posedge clock) begin
    if (reset) wd_q <= '0;
    else       wd_q <= wd_d;
  end
`endif

  assign busy        = busy_q;
  assign done        = done_q;
  assign result      = result_q;
  assign timeout_err = terr_q;
  assign proc_reset  = prst_q;
  assign proc_dataIn = din_q;
  assign proc_enter  = enter_q;

endmodule

// File: tb/tb_gcd_operand_feeder.sv
// tb/tb_gcd_operand_feeder.sv - self-checking bench with a behavioural GCD processor and cycle timeline model.
module tb_gcd_operand_feeder;

  localparam int RST = 2, S = 3, E = 3, G = 3;
  localparam int P = S + E + G;
  localparam int T = RST + 2 * P;
  localparam int LIM = 60;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] x_in = '0, y_in = '0;
  logic       busy, done, timeout_err, proc_reset, proc_enter, proc_halt;
  logic [7:0] result, proc_dataIn, proc_dataOut;

  gcd_operand_feeder #(
    .DATA_W(8), .RST_CYCLES(RST), .SETUP_CYCLES(S), .ENTER_HOLD(E), .GAP_CYCLES(G)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .x_in(x_in), .y_in(y_in),
    .busy(busy), .done(done), .result(result), .timeout_err(timeout_err),
    .proc_reset(proc_reset), .proc_dataIn(proc_dataIn), .proc_enter(proc_enter),
    .proc_halt(proc_halt), .proc_dataOut(proc_dataOut)
  );

  always #5 clock = ~clock;

  function automatic logic [7:0] ref_gcd(input logic [7:0] a_in, input logic [7:0] b_in);
    int a, b, t;
    a = int'(a_in);
    b = int'(b_in);
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return 8'(a);
  endfunction

  // Behavioural processor: captures operands on enter rising edges, raises Halt after a delay.
  int         halt_delay = 0;
  logic       force_halt = 1'b0;
  logic       halt_m, prev_en;
  logic [7:0] cap_x, cap_y, dout_m;
  int         ncap, cnt_m;

  always @(posedge clock) begin
    if (proc_reset) begin
      ncap    <= 0;
      halt_m  <= 1'b0;
      cnt_m   <= 0;
      dout_m  <= 8'hA5;
      prev_en <= 1'b0;
    end else begin
      prev_en <= proc_enter;
      if (proc_enter && !prev_en) begin
        if (ncap == 0) cap_x <= proc_dataIn;
        else           cap_y <= proc_dataIn;
        if (ncap == 1) cnt_m <= halt_delay;
        ncap <= ncap + 1;
      end else if (ncap == 2 && !halt_m) begin
        if (cnt_m == 0) begin
          halt_m <= 1'b1;
          dout_m <= ref_gcd(cap_x, cap_y);
        end else begin
          cnt_m <= cnt_m - 1;
        end
      end
    end
  end

  assign proc_halt    = halt_m | force_halt;
  assign proc_dataOut = dout_m;

  int total = 0, bad = 0;
  logic [7:0] prev_result = 8'd0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0] x;
    logic [7:0] y;
    int         hd;
    logic [7:0] exp;
  } vec_t;

  // mode 0 plain, 1 stray start in ENTER_X, 2 stale halt in SETUP_X/GAP_X, 3 start during DONE
  task automatic run(input vec_t v, input int mode);
    int   pred, dcnt;
    logic exp_en;
    logic [7:0] ed;
    start = 1'b1; x_in = v.x; y_in = v.y; halt_delay = v.hd;
    @(negedge clock);
    start = 1'b0;
    pred = -1;
    dcnt = 0;
    for (int k = 1; k <= T + LIM; k++) begin
      if (pred > 0 && k == pred + 1) begin
        chk("busy_after_done", int'(busy), 0);
        chk("prst_after_done", int'(proc_reset), 1);
        chk("done_after_done", int'(done), 0);
        start = 1'b0;
        break;
      end
      exp_en = (k > RST + S && k <= RST + S + E) || (k > RST + P + S && k <= RST + P + S + E);
      if (k == pred || k <= RST) ed = 8'd0;
      else if (k <= RST + P)     ed = v.x;
      else                       ed = v.y;
      chk("dataIn", int'(proc_dataIn), int'(ed));
      chk("enter", int'(proc_enter), (k == pred) ? 0 : int'(exp_en));
      chk("proc_reset", int'(proc_reset), (k <= RST) ? 1 : 0);
      chk("busy", int'(busy), 1);
      chk("done", int'(done), (k == pred) ? 1 : 0);
      chk("result", int'(result), (k == pred) ? int'(v.exp) : int'(prev_result));
      if (done) dcnt++;
      if (k > T && pred < 0 && proc_halt) pred = k + 1;
      if (mode == 1) begin
        if (k == RST + S + 1) begin start = 1'b1; x_in = 8'd99; end
        else start = 1'b0;
      end
      if (mode == 2)
        force_halt = (k > RST && k <= RST + S) || (k > RST + S + E && k <= RST + P);
      if (mode == 3 && k == pred) begin start = 1'b1; x_in = 8'h33; end
      @(negedge clock);
    end
    force_halt = 1'b0;
    chk("done_seen", int'(pred > 0), 1);
    chk("done_count", dcnt, 1);
    chk("cap_x", int'(cap_x), int'(v.x));
    chk("cap_y", int'(cap_y), int'(v.y));
    prev_result = v.exp;
    repeat (2) @(negedge clock);
  endtask

  task automatic reset_mid();
    int dcnt;
    start = 1'b1; x_in = 8'd48; y_in = 8'd18; halt_delay = 0;
    @(negedge clock);
    start = 1'b0;
    for (int k = 1; k < RST + P + S + 1; k++) @(negedge clock);
    chk("enter_y_pre_reset", int'(proc_enter), 1);
    reset = 1'b1;
    @(negedge clock);
    chk("rst_enter", int'(proc_enter), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_prst", int'(proc_reset), 1);
    chk("rst_result", int'(result), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_dataIn", int'(proc_dataIn), 0);
    reset = 1'b0;
    dcnt = 0;
    repeat (12) begin
      @(negedge clock);
      if (done || busy) dcnt++;
    end
    chk("rst_quiet", dcnt, 0);
    prev_result = 8'd0;
  endtask

  vec_t tbl[7];

  initial begin
    tbl[0] = '{x: 8'd51,  y: 8'd22,  hd: 2, exp: 8'd1};
    tbl[1] = '{x: 8'd48,  y: 8'd18,  hd: 0, exp: 8'd6};
    tbl[2] = '{x: 8'd0,   y: 8'd5,   hd: 1, exp: 8'd5};
    tbl[3] = '{x: 8'd7,   y: 8'd7,   hd: 3, exp: 8'd7};
    tbl[4] = '{x: 8'd255, y: 8'd17,  hd: 9, exp: 8'd17};
    tbl[5] = '{x: 8'd1,   y: 8'd200, hd: 5, exp: 8'd1};
    tbl[6] = '{x: 8'd100, y: 8'd75,  hd: 14, exp: 8'd25};

    repeat (3) @(negedge clock);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_result", int'(result), 0);
    chk("reset_prst", int'(proc_reset), 1);
    chk("reset_dataIn", int'(proc_dataIn), 0);
    chk("reset_enter", int'(proc_enter), 0);
    chk("reset_terr", int'(timeout_err), 0);
    reset = 1'b0;
    @(negedge clock);

    for (int i = 0; i < 7; i++) run(tbl[i], 0);
    run(tbl[1], 1);
    run(tbl[1], 2);
    run(tbl[0], 3);
    reset_mid();

    for (int i = 0; i < 8; i++) begin
      vec_t r;
      r.x   = 8'($urandom_range(0, 255));
      r.y   = 8'($urandom_range(0, 255));
      r.hd  = int'($urandom_range(0, 10));
      r.exp = ref_gcd(r.x, r.y);
      run(r, int'($urandom_range(0, 3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
